// File: rtl/audio_frame_buffer_if.sv
// Handshake and frame bus between the sample source / min-max stage and the
// ping-pong frame buffer.
interface audio_frame_buffer_if #(
  parameter int N     = 100,
  parameter int W     = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic             in_ready;
  logic [N*W-1:0]   frame_data;
  logic             frame_start;
  logic             frame_done;
  logic [CNT_W-1:0] frame_cnt;
  logic             stall;

  // Driver side: upstream source plus the min/max stage's done pulse.
  modport master (
    output in_valid, in_data, frame_done,
    input  in_ready, frame_data, frame_start, frame_cnt, stall
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, frame_done,
    output in_ready, frame_data, frame_start, frame_cnt, stall
  );
endinterface

// File: rtl/audio_frame_buffer.sv
// Ping-pong frame buffer: one bank fills from the sample stream while the
// other is held on frame_data for the min/max stage until it reports done.
//
// state  | meaning
// W_FILL | write bank accepting samples
// W_FULL | write bank complete, waiting for the read bank to be released
// R_IDLE | no frame outstanding at the min/max stage
// R_BUSY | frame issued, waiting for frame_done
module audio_frame_buffer #(
  parameter int N     = 100,
  parameter int W     = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  audio_frame_buffer_if.slave bus
);
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(N - 1);

  typedef enum logic {W_FILL, W_FULL} wr_state_t;
  typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

  wr_state_t        wr_st_q, wr_st_d;
  rd_state_t        rd_st_q, rd_st_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             frame_start_q, frame_start_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             stall_q, stall_d;
  logic [W-1:0]     bank_q [2][N];
  logic [N*W-1:0]   frame_data_w;

  logic accept, complete, swap;

  // Next-state logic for both FSMs, pointer, bank roles and frame counter.
  always_comb begin
    wr_st_d       = wr_st_q;
    rd_st_d       = rd_st_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    wr_ptr_d      = wr_ptr_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    // in_ready_q is already the registered FILL decode, so it gates accepts.
    accept   = bus.in_valid && in_ready_q;
    complete = accept && (wr_ptr_q == LAST);
    // A full bank can only exist while the read side is busy, so frame_done
    // alone releases it.
    swap     = (complete && ((rd_st_q == R_IDLE) || bus.frame_done)) ||
               ((wr_st_q == W_FULL) && bus.frame_done);

    if (accept) begin
      wr_ptr_d = complete ? '0 : wr_ptr_q + 1'b1;
    end

    if (swap) begin
      rd_bank_d     = wr_bank_q;
      wr_bank_d     = ~wr_bank_q;
      wr_ptr_d      = '0;
      rd_st_d       = R_BUSY;
      wr_st_d       = W_FILL;
      frame_start_d = 1'b1;
      frame_cnt_d   = frame_cnt_q + 1'b1;
    end else if (complete) begin
      wr_st_d = W_FULL;
    end else if ((rd_st_q == R_BUSY) && bus.frame_done) begin
      rd_st_d = R_IDLE;
    end

    in_ready_d = (wr_st_d == W_FILL);
    stall_d    = (wr_st_d == W_FULL);
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_st_q       <= W_FILL;
      rd_st_q       <= R_IDLE;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      wr_ptr_q      <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      in_ready_q    <= 1'b0;
      stall_q       <= 1'b0;
    end else begin
      wr_st_q       <= wr_st_d;
      rd_st_q       <= rd_st_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      wr_ptr_q      <= wr_ptr_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      in_ready_q    <= in_ready_d;
      stall_q       <= stall_d;
    end
  end

  // Sample storage; not cleared by reset, written only on an accept.
  always_ff @(posedge clk) begin
    if (reset && accept) begin
      bank_q[wr_bank_q][wr_ptr_q] <= bus.in_data;
    end
  end

  // Flatten the read bank, sample k at word k.
  always_comb begin
    frame_data_w = '0;
    for (int k = 0; k < N; k++) begin
      frame_data_w[k*W +: W] = bank_q[rd_bank_q][k];
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.stall       = stall_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.frame_data  = frame_data_w;
endmodule
